if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction-fetch stage of the RISC-V core. Sits directly upstream of the IF/ID pipeline register.
- Holds the PC and fetches each 32-bit instruction from the byte-wide memory controller as 4 little-endian bytes.
- Presents {pc, instruction} to IF/ID and handles stall from downstream and redirect from EX.
- Emits the one-cycle squash flag consumed by IF/ID.

Parameters:
- RESET_PC, 32'h00000000, PC loaded on reset.
- ICACHE_LINES, 16, entry count of the optional I-cache (power of 2, ≥2). Ignored when the cache is compiled out.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- stl_if  in  1  downstream stall; hold the presented instruction.
- br_en  in  1  redirect request from EX, one-cycle pulse.
- br_target  in  32  redirect PC; bits [1:0] forced to 0.
- mem_req  out  1  byte fetch request.
- mem_addr  out  32  byte address of current request.
- mem_data  in  8  returned byte, valid when mem_rdy=1.
- mem_rdy  in  1  byte accepted/returned this cycle; only legal while mem_req=1.
- if_pc  out  32  PC of presented instruction (to IF/ID).
- if_is  out  32  presented instruction; 32'h0 = bubble.
- not_ok  out  1  squash flag to IF/ID, high for the cycle after a redirect.

Behaviour:
- Reset (async, active-high):
  - state=S_IDLE, pc=RESET_PC, cnt=0, byte buffer=0.
  - if_pc=RESET_PC, if_is=0, not_ok=0, mem_req=0, mem_addr=RESET_PC.
- States:
  - S_IDLE: entered only from reset. mem_req=0. Goes to S_FETCH next cycle.
  - S_FETCH: mem_req=1, mem_addr=pc+cnt (32-bit wrap), if_is=0.
    - On mem_rdy: byte buf[cnt] <= mem_data, cnt <= cnt+1.
    - On mem_rdy with cnt==3: instr <= {mem_data, buf[2], buf[1], buf[0]}, cnt <= 0, go S_HOLD.
    - Minimum fetch = 4 cycles. Unlimited wait states between bytes.
  - S_HOLD: mem_req=0, if_is=instr, if_pc=pc.
    - If stl_if=0: pc <= pc+4 (wrap at 2^32), go S_FETCH. The instruction is therefore visible for exactly one edge.
    - If stl_if=1: stay; if_pc/if_is held stable.
- if_pc equals pc in all states. if_is is nonzero only in S_HOLD.
- Redirect (br_en=1 at an edge, any state except during reset):
  - pc <= {br_target[31:2], 2'b00}, cnt <= 0, state <= S_FETCH.
  - Any byte returned that cycle (mem_rdy=1) is discarded.
  - Highest priority: overrides stl_if and fetch completion.
  - not_ok <= 1 for exactly the next cycle, then 0. Back-to-back br_en keeps not_ok high and the last target wins.
- br_en during S_IDLE: accepted, behaves as above.
- Output timing:
  - mem_req and mem_addr are combinational from state/pc/cnt.
  - mem_req must never be high in S_IDLE or S_HOLD.
  - if_pc, if_is and not_ok are driven from registers only; no input-to-output combinational path.
- Reset asserted mid-fetch: partial bytes are dropped and the fetch restarts at RESET_PC after S_IDLE.

Optional Feature:
- Macro: IF_ICACHE_EN.
- Defined: direct-mapped instruction cache of ICACHE_LINES one-word entries.
  - Index = pc[log2(ICACHE_LINES)+1:2]; tag = remaining upper pc bits; per-entry valid bit.
  - Reset clears all valid bits.
  - In the first S_FETCH cycle (cnt==0) on a hit: mem_req=0, instr <= cached word, go S_HOLD next cycle (1-cycle fetch).
  - On a miss: normal byte fetch, and the 4th byte writes data, tag and valid.
  - No invalidation port; instruction memory is read-only (fence.i unsupported).
  - A redirect during a miss fill aborts without writing.
- Undefined: no cache storage; every fetch takes the byte path.

Test Plan:
- Reset then release, memory returns bytes 13,00,50,00 at addr 0..3 with mem_rdy every cycle → mem_req low 1 cycle, mem_addr 0,1,2,3; S_HOLD shows if_pc=0, if_is=32'h00500013, then mem_addr=4.
- stl_if=1 for 3 cycles during S_HOLD of pc=4 → if_is/if_pc stable 3 cycles, mem_req=0; after release next mem_addr=8.
- br_en=1, br_target=32'h00000107 while cnt=2 with mem_rdy=1 → byte discarded, next mem_addr=32'h104, not_ok=1 one cycle, if_is=0 until new fetch completes.
- mem_rdy asserted every 3rd cycle → fetch of one word takes 12 cycles; assembled word correct; mem_addr steps only on mem_rdy.
- pc=32'hFFFFFFFC fetch completes with stl_if=0 → next mem_addr=32'h00000000.
- IF_ICACHE_EN: loop of 2 instructions at 0x0/0x4 via br_en to 0 → second pass has mem_req=0 and S_HOLD one cycle after entering S_FETCH; if_is matches first pass; rst clears cache so the next pass misses.

Source files
------------

// File: rtl/if_stage.sv
// if_stage -- instruction-fetch stage of the RISC-V core.
//
// Holds the PC, fetches each 32-bit instruction from the byte-wide memory
// controller as four little-endian bytes, and presents {pc, instruction} to
// the IF/ID register. Handles downstream stall and EX redirect, and emits the
// one-cycle squash flag consumed by IF/ID.
//
// Optional feature (macro IF_ICACHE_EN): a direct-mapped instruction cache of
// ICACHE_LINES one-word entries. A hit in the first fetch cycle skips the byte
// path and completes in one cycle. With the macro undefined there is no cache
// storage and every fetch takes the byte path.
//
// Ports:
//   clk        in   1   clock, rising edge
//   rst        in   1   asynchronous, active-high reset
//   stl_if     in   1   downstream stall; hold the presented instruction
//   br_en      in   1   redirect request from EX (one-cycle pulse)
//   br_target  in  32   redirect PC; bits [1:0] are ignored (forced to 0)
//   mem_req    out  1   byte fetch request
//   mem_addr   out 32   byte address of the current request
//   mem_data   in   8   returned byte, valid when mem_rdy=1
//   mem_rdy    in   1   byte accepted/returned this cycle
//   if_pc      out 32   PC of the presented instruction
//   if_is      out 32   presented instruction; 32'h0 is a bubble
//   not_ok     out  1   squash flag, high for the cycle after a redirect
module if_stage #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned ICACHE_LINES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stl_if,
  input  logic        br_en,
  input  logic [31:0] br_target,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [7:0]  mem_data,
  input  logic        mem_rdy,
  output logic [31:0] if_pc,
  output logic [31:0] if_is,
  output logic        not_ok
);

  if (ICACHE_LINES < 2 || (ICACHE_LINES & (ICACHE_LINES - 1)) != 0) begin : g_bad_lines
    $error("ICACHE_LINES must be a power of 2 and at least 2");
  end

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFetch = 2'd1,
    StHold  = 2'd2
  } state_e;

  state_e          state_q;
  logic [31:0]     pc_q;
  logic [1:0]      cnt_q;
  logic [2:0][7:0] byte_q;   // bytes 0..2 of the word being assembled
  logic [31:0]     instr_q;
  logic            not_ok_q;

  logic [31:0] br_pc;
  logic [31:0] full_word;
  logic        last_byte;
  logic        hit;
  logic [31:0] hit_word;

  // Low target bits are dropped: fetch is always word aligned.
  logic unused_tgt_bits;
  assign unused_tgt_bits = ^br_target[1:0];

  assign br_pc     = {br_target[31:2], 2'b00};
  assign full_word = {mem_data, byte_q[2], byte_q[1], byte_q[0]};
  assign last_byte = (state_q == StFetch) && mem_rdy && (cnt_q == 2'd3);

`ifdef IF_ICACHE_EN
  localparam int unsigned IdxW = $clog2(ICACHE_LINES);
  localparam int unsigned TagW = 30 - IdxW;

  logic [ICACHE_LINES-1:0] valid_q;
  logic [TagW-1:0]         tag_q  [ICACHE_LINES];
  logic [31:0]             data_q [ICACHE_LINES];

  logic [IdxW-1:0] idx;
  logic [TagW-1:0] tag;
  logic            fill;

  assign idx      = pc_q[IdxW+1:2];
  assign tag      = pc_q[31:IdxW+2];
  assign hit      = (state_q == StFetch) && (cnt_q == 2'd0) && valid_q[idx] &&
                    (tag_q[idx] == tag);
  assign hit_word = data_q[idx];
  // A redirect in the same cycle aborts the fill.
  assign fill     = last_byte && !hit && !br_en;

  // Cache payload needs no reset; valid bits gate every use.
  always_ff @(posedge clk) begin
    if (fill) begin
      tag_q[idx]  <= tag;
      data_q[idx] <= full_word;
    end
  end
`else
  assign hit      = 1'b0;
  assign hit_word = 32'h0;
`endif

  // Single-process FSM; all presented outputs come straight from registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      pc_q     <= RESET_PC;
      cnt_q    <= 2'd0;
      byte_q   <= '0;
      instr_q  <= 32'h0;
      not_ok_q <= 1'b0;
`ifdef IF_ICACHE_EN
      valid_q  <= '0;
`endif
    end else begin
      // Stays high across back-to-back redirects.
      not_ok_q <= br_en;
      if (br_en) begin
        // Redirect beats stall and fetch completion; any byte returned now is dropped.
        pc_q    <= br_pc;
        cnt_q   <= 2'd0;
        state_q <= StFetch;
      end else begin
        unique case (state_q)
          StIdle: begin
            state_q <= StFetch;
          end
          StFetch: begin
            if (hit) begin
              instr_q <= hit_word;
              state_q <= StHold;
            end else if (mem_rdy) begin
              if (cnt_q == 2'd3) begin
                instr_q <= full_word;
                cnt_q   <= 2'd0;
                state_q <= StHold;
              end else begin
                byte_q[cnt_q] <= mem_data;
                cnt_q         <= cnt_q + 2'd1;
              end
            end
          end
          StHold: begin
            if (!stl_if) begin
              pc_q    <= pc_q + 32'd4;
              state_q <= StFetch;
            end
          end
          default: begin
            state_q <= StIdle;
          end
        endcase
      end
`ifdef IF_ICACHE_EN
      if (fill) begin
        valid_q[idx] <= 1'b1;
      end
`endif
    end
  end

  assign mem_req  = (state_q == StFetch) && !hit;
  assign mem_addr = pc_q + {30'b0, cnt_q};
  assign if_pc    = pc_q;
  assign if_is    = (state_q == StHold) ? instr_q : 32'h0;
  assign not_ok   = not_ok_q;

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stl_if = 1'b0;
  logic        br_en = 1'b0;
  logic [31:0] br_target = 32'h0;
  logic        rdy = 1'b0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [7:0]  mem_data;
  logic        mem_rdy;
  logic [31:0] if_pc;
  logic [31:0] if_is;
  logic        not_ok;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  if_stage #(
    .RESET_PC    (32'h0000_0000),
    .ICACHE_LINES(16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .stl_if   (stl_if),
    .br_en    (br_en),
    .br_target(br_target),
    .mem_req  (mem_req),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .mem_rdy  (mem_rdy),
    .if_pc    (if_pc),
    .if_is    (if_is),
    .not_ok   (not_ok)
  );

  // Memory model: instruction 32'h00500013 at 0..3, a address-derived pattern elsewhere.
  function automatic logic [7:0] mb(input logic [31:0] a);
    case (a)
      32'd0:   return 8'h13;
      32'd1:   return 8'h00;
      32'd2:   return 8'h50;
      32'd3:   return 8'h00;
      default: return (a[7:0] * 8'd7) ^ a[31:24] ^ 8'h3C;
    endcase
  endfunction

  function automatic logic [31:0] ew(input logic [31:0] a);
    return {mb(a + 32'd3), mb(a + 32'd2), mb(a + 32'd1), mb(a)};
  endfunction

  assign mem_data = mb(mem_addr);
  assign mem_rdy  = rdy & mem_req;

  typedef struct {
    logic        stl;
    logic        br;
    logic [31:0] tgt;
    logic        ereq;
    logic [31:0] eaddr;
    logic [31:0] epc;
    logic [31:0] eis;
    logic        enok;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic stl, input logic br, input logic [31:0] tgt,
                              input logic ereq, input logic [31:0] eaddr,
                              input logic [31:0] epc, input logic [31:0] eis,
                              input logic enok);
    vec_t v;
    v.stl = stl; v.br = br; v.tgt = tgt; v.ereq = ereq; v.eaddr = eaddr;
    v.epc = epc; v.eis = eis; v.enok = enok;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset and check the reset state; ends just after a rising edge, in StIdle.
  task automatic do_reset(input string tag);
    rst = 1'b1; stl_if = 1'b0; br_en = 1'b0; rdy = 1'b0;
    #1;
    chk({tag, "_rst_req"}, {31'b0, mem_req}, 32'd0);
    chk({tag, "_rst_addr"}, mem_addr, 32'h0);
    chk({tag, "_rst_pc"}, if_pc, 32'h0);
    chk({tag, "_rst_is"}, if_is, 32'h0);
    chk({tag, "_rst_nok"}, {31'b0, not_ok}, 32'd0);
    tick();
    rst = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int i);
    stl_if = v.stl; br_en = v.br; br_target = v.tgt; rdy = 1'b1;
    #1;
    chk($sformatf("v%0d_req", i), {31'b0, mem_req}, {31'b0, v.ereq});
    chk($sformatf("v%0d_addr", i), mem_addr, v.eaddr);
    chk($sformatf("v%0d_pc", i), if_pc, v.epc);
    chk($sformatf("v%0d_is", i), if_is, v.eis);
    chk($sformatf("v%0d_nok", i), {31'b0, not_ok}, {31'b0, v.enok});
    tick();
  endtask

  initial begin
    int k;
    int exp_cnt;

    // stl, br, tgt, req, addr, pc, is, nok
    vecs.push_back(mk(0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0));                 // idle
    vecs.push_back(mk(0, 0, 0, 1, 32'h0, 32'h0, 32'h0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 32'h1, 32'h0, 32'h0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 32'h2, 32'h0, 32'h0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 32'h3, 32'h0, 32'h0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0, 32'h0, 32'h0050_0013, 0));         // hold pc 0
    vecs.push_back(mk(0, 0, 0, 1, 32'h4, 32'h4, 32'h0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 32'h5, 32'h4, 32'h0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 32'h6, 32'h4, 32'h0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 32'h7, 32'h4, 32'h0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 32'h4, 32'h4, ew(32'h4), 0));             // stalled hold
    vecs.push_back(mk(1, 0, 0, 0, 32'h4, 32'h4, ew(32'h4), 0));
    vecs.push_back(mk(1, 0, 0, 0, 32'h4, 32'h4, ew(32'h4), 0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h4, 32'h4, ew(32'h4), 0));
    vecs.push_back(mk(0, 0, 0, 1, 32'h8, 32'h8, 32'h0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 32'h9, 32'h8, 32'h0, 0));
    vecs.push_back(mk(0, 1, 32'h107, 1, 32'hA, 32'h8, 32'h0, 0));           // redirect at cnt 2
    vecs.push_back(mk(0, 0, 0, 1, 32'h104, 32'h104, 32'h0, 1));
    vecs.push_back(mk(0, 0, 0, 1, 32'h105, 32'h104, 32'h0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 32'h106, 32'h104, 32'h0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 32'h107, 32'h104, 32'h0, 0));
    vecs.push_back(mk(1, 1, 32'h203, 0, 32'h104, 32'h104, ew(32'h104), 0)); // redirect beats stall
    vecs.push_back(mk(0, 1, 32'hFFFF_FFFF, 1, 32'h200, 32'h200, 32'h0, 1)); // back-to-back
    vecs.push_back(mk(0, 0, 0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0, 1));
    vecs.push_back(mk(0, 0, 0, 1, 32'hFFFF_FFFD, 32'hFFFF_FFFC, 32'h0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 32'hFFFF_FFFE, 32'hFFFF_FFFC, 32'h0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, ew(32'hFFFF_FFFC), 0));
    vecs.push_back(mk(0, 0, 0, 1, 32'h0, 32'h0, 32'h0, 0));                 // pc wrapped

    do_reset("t");
    for (int i = 0; i < vecs.size(); i++) begin
      run_vec(vecs[i], i);
    end

    // Redirect while idle, then reset in the middle of the fetch.
    do_reset("a");
    br_en = 1'b1; br_target = 32'h42; rdy = 1'b1;
    tick();
    br_en = 1'b0;
    chk("a_br_idle_addr", mem_addr, 32'h40);
    chk("a_br_idle_nok", {31'b0, not_ok}, 32'd1);
    tick();
    tick();
    chk("a_mid_addr", mem_addr, 32'h42);
    rst = 1'b1;
    #1;
    chk("a_async_req", {31'b0, mem_req}, 32'd0);
    chk("a_async_addr", mem_addr, 32'h0);
    chk("a_async_pc", if_pc, 32'h0);
    tick();
    rst = 1'b0;
    tick();  // idle
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("a_refetch_addr%0d", i), mem_addr, 32'(i));
      tick();
    end
    chk("a_refetch_is", if_is, 32'h0050_0013);
    chk("a_refetch_req", {31'b0, mem_req}, 32'd0);

    // Wait states: a byte every third cycle, twelve fetch cycles per word.
    do_reset("w");
    rdy = 1'b0;
    tick();  // idle -> fetch
    k = 0;
    exp_cnt = 0;
    while (k < 40) begin
      rdy = (k % 3 == 2);
      #1;
      if (!mem_req) break;
      chk($sformatf("w_addr_c%0d", k), mem_addr, 32'(exp_cnt));
      if (rdy) exp_cnt++;
      k++;
      @(posedge clk);
      #1;
    end
    chk("w_cycles", 32'(k), 32'd12);
    chk("w_is", if_is, 32'h0050_0013);
    chk("w_pc", if_pc, 32'h0);
    rdy = 1'b1;

    // Refetch of address 0 after a pass: hit path only with the cache built in.
    do_reset("c");
    rdy = 1'b1;
    repeat (5) tick();         // idle + 4 bytes
    chk("c_p1_is", if_is, 32'h0050_0013);
    repeat (5) tick();         // fetch pc 4
    chk("c_p1_is4", if_is, ew(32'h4));
    br_en = 1'b1; br_target = 32'h0;
    tick();
    br_en = 1'b0;
`ifdef IF_ICACHE_EN
    chk("c_hit_req", {31'b0, mem_req}, 32'd0);
    tick();
    chk("c_hit_is", if_is, 32'h0050_0013);
    do_reset("c2");
    tick();
    chk("c_after_rst_req", {31'b0, mem_req}, 32'd1);
`else
    chk("c_nocache_req", {31'b0, mem_req}, 32'd1);
    repeat (4) tick();
    chk("c_nocache_is", if_is, 32'h0050_0013);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
